ball_write_arbiter: RTL and testbench
=====================================

Name: ball_write_arbiter

Overview:
- Shares the velocity-write port of every ball_logic instance among three requesters: cue strike, wall-collision resolver and ball-pair-collision resolver.
- Owns distribution of the frame tick to the balls, so a velocity write and a position update never land in the same cycle. Ball_logic gives a write priority over the frame update.
- Sits between the frame/collision logic and the ball_logic array.

Parameters:
- NUM_BALLS, 16, number of ball_logic instances
- IDX_W, 4, ball index width (clog2 NUM_BALLS)
- VEL_W, 11, signed velocity width

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle frame pulse from video timing
- ballStopped  in  NUM_BALLS  per-ball stopped flag
- cueReq / cueBall / cueVelX / cueVelY  in  1 / IDX_W / VEL_W / VEL_W  cue strike request
- cueAck  out  1  cue request accepted
- wallReq / wallBall / wallVelX / wallVelY  in  1 / IDX_W / VEL_W / VEL_W  wall bounce request
- wallAck  out  1
- pairReq / pairBallA / pairVelAX / pairVelAY / pairBallB / pairVelBX / pairVelBY  in  1 / IDX_W / VEL_W x2 / IDX_W / VEL_W x2  two-ball collision request
- pairAck  out  1
- velocityWriteEnable  out  NUM_BALLS  one-hot write strobe to ball_logic
- outVelocityX / outVelocityY  out  VEL_W  signed velocity bus shared by all balls
- ballFrameTick  out  1  frame pulse to all ball_logic startOfFrame inputs
- tableIdle  out  1  all balls stopped and arbiter in IDLE

Behaviour:
- Outputs and reset:
  - All outputs are registered.
  - Reset values: all outputs 0, FSM = IDLE, lock vector 0, tickPending 0, rrLast = WALL.
  - Reset mid-pair aborts with no further strobe.
- Requester handshake:
  - Requester holds req and data stable until its ack.
  - Ack is a one-cycle pulse.
  - Requester drops req the cycle after ack.
  - The arbiter masks the just-acked requester for the decision cycle in which its ack is high.
- FSM states:
  - IDLE: one decision per cycle, evaluated in this order:
    1. If tickPending or startOfFrame: next cycle ballFrameTick=1, no strobe, lock vector cleared, tickPending cleared.
    2. Else if cueReq, all ballStopped=1 and cueBall unlocked: grant cue.
    3. Else grant between eligible pair and wall round-robin; the one not granted last wins.
       - Wall is eligible if wallBall is unlocked.
       - Pair is eligible only if both A and B are unlocked.
  - Single grant (cue/wall):
    - Next cycle: strobe bit [ball]=1, bus = request velocity, ack=1, lock[ball] set.
    - FSM stays IDLE.
  - Pair grant:
    - Next cycle WRITE_A: strobe A, bus = VelA, lock A.
    - Then WRITE_B: strobe B, bus = VelB, lock B, pairAck=1.
    - Then IDLE.
    - Pair writes are never split by a frame tick.
- Frame tick:
  - startOfFrame arriving in WRITE_A or WRITE_B sets tickPending.
  - The tick is emitted on the first IDLE decision.
  - Tick latency is 1 cycle nominally, at most 3.
  - ballFrameTick and any strobe are never high together.
  - Frames are never dropped. startOfFrame during a pending tick merges into it; frame spacing is ≥ 4 cycles.
- Lock:
  - At most one write per ball per frame.
  - A request touching a locked ball is held pending (no ack) until after the next tick.
- Degenerate pair: pairBallA == pairBallB is acked with a single write of VelA; B is dropped.
- tableIdle = AND of ballStopped, FSM == IDLE, and no strobe this cycle. Registered.
- No velocity arithmetic: data passes through unchanged, and ball_logic performs clamping.
- Index ≥ NUM_BALLS: the request is acked, with no strobe.

Decomposition:
- Package ball_pkg:
  - NUM_BALLS, IDX_W, VEL_W constants
  - typedef arb_state_t {IDLE, WRITE_A, WRITE_B}
  - typedef requester_t {REQ_CUE, REQ_WALL, REQ_PAIR}
  - velocity vector struct {x, y}
- Sub-module ball_lock_table holds the lock bits, with inputs setA, setB, clearAll and a lookup on up to two indices.

Test Plan:
- Wall request only: wallReq, ball 3, (12,-7) at cycle n → cycle n+1: strobe[3]=1, bus=(12,-7), wallAck=1; no other strobe.
- Pair (2, 5), velocities (40,0)/(-40,0) → WRITE_A: strobe[2]=1 with bus (40,0); next cycle strobe[5]=1 with bus (-40,0) and pairAck=1.
- Pair and wall held every cycle with distinct unlocked balls → grants alternate; neither starves.
- startOfFrame in the WRITE_A cycle → WRITE_B completes, then ballFrameTick=1 with strobe=0; tick is not lost.
- Second wall request to ball 3 in the same frame → no ack until after ballFrameTick; then it is granted.
- cueReq while ballStopped≠all-ones → no cueAck; once all are stopped → granted ahead of a simultaneous wallReq.
- Assert resetN=0 during WRITE_A → all outputs 0 immediately; after release, no B strobe.

Source files
------------

// File: rtl/ball_write_arbiter_pkg.sv
// Shared constants, types and small index helpers for the ball write arbiter.
package ball_pkg;

    localparam int NUM_BALLS = 16;
    localparam int IDX_W     = 4;
    localparam int VEL_W     = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE_A = 2'd1,
        WRITE_B = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_CUE  = 2'd0,
        REQ_WALL = 2'd1,
        REQ_PAIR = 2'd2
    } requester_t;

    typedef struct packed {
        logic signed [VEL_W-1:0] x;
        logic signed [VEL_W-1:0] y;
    } vel_vec_t;

    // True when the index addresses an existing ball.
    function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
        return (int'(idx) < NUM_BALLS);
    endfunction

    // One-hot ball strobe; an index past the last ball selects nothing.
    function automatic logic [NUM_BALLS-1:0] ball_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_BALLS-1:0] v;
        v = '0;
        if (idx_valid(idx)) begin
            v[idx] = 1'b1;
        end else begin
            v = '0;
        end
        return v;
    endfunction

    // Lock bit of a ball; nonexistent balls never count as locked.
    function automatic logic lock_lookup(input logic [NUM_BALLS-1:0] locks,
                                         input logic [IDX_W-1:0]     idx);
        logic hit;
        hit = 1'b0;
        if (idx_valid(idx)) begin
            hit = locks[idx];
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ball_write_arbiter_lock_table.sv
// Per-ball "already written this frame" bits with two set ports, a frame
// clear and a two-index lookup.
module ball_lock_table
    import ball_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 i_set_a,
    input  logic [IDX_W-1:0]     i_set_idx_a,
    input  logic                 i_set_b,
    input  logic [IDX_W-1:0]     i_set_idx_b,
    input  logic                 i_clear_all,
    input  logic [IDX_W-1:0]     i_look_idx_a,
    input  logic [IDX_W-1:0]     i_look_idx_b,
    output logic                 o_locked_a,
    output logic                 o_locked_b,
    output logic [NUM_BALLS-1:0] o_lock_vec
);

    logic [NUM_BALLS-1:0] r_locks;

    // Frame clear wins; otherwise accumulate the balls written this cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_locks <= '0;
        end else if (i_clear_all) begin
            r_locks <= '0;
        end else begin
            r_locks <= r_locks
                     | (ball_onehot(i_set_idx_a) & {NUM_BALLS{i_set_a}})
                     | (ball_onehot(i_set_idx_b) & {NUM_BALLS{i_set_b}});
        end
    end

    assign o_locked_a = lock_lookup(r_locks, i_look_idx_a);
    assign o_locked_b = lock_lookup(r_locks, i_look_idx_b);
    assign o_lock_vec = r_locks;

endmodule

// File: rtl/ball_write_arbiter.sv
// Arbitrates the shared ball velocity-write port between cue, wall and
// ball-pair requesters and interleaves the frame tick so that a velocity
// write and a position update never share a cycle.
module ball_write_arbiter
    import ball_pkg::*;
(
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic [NUM_BALLS-1:0]    ballStopped,
    input  logic                    cueReq,
    input  logic [IDX_W-1:0]        cueBall,
    input  logic signed [VEL_W-1:0] cueVelX,
    input  logic signed [VEL_W-1:0] cueVelY,
    output logic                    cueAck,
    input  logic                    wallReq,
    input  logic [IDX_W-1:0]        wallBall,
    input  logic signed [VEL_W-1:0] wallVelX,
    input  logic signed [VEL_W-1:0] wallVelY,
    output logic                    wallAck,
    input  logic                    pairReq,
    input  logic [IDX_W-1:0]        pairBallA,
    input  logic signed [VEL_W-1:0] pairVelAX,
    input  logic signed [VEL_W-1:0] pairVelAY,
    input  logic [IDX_W-1:0]        pairBallB,
    input  logic signed [VEL_W-1:0] pairVelBX,
    input  logic signed [VEL_W-1:0] pairVelBY,
    output logic                    pairAck,
    output logic [NUM_BALLS-1:0]    velocityWriteEnable,
    output logic signed [VEL_W-1:0] outVelocityX,
    output logic signed [VEL_W-1:0] outVelocityY,
    output logic                    ballFrameTick,
    output logic                    tableIdle
);

    arb_state_t              r_state, w_state_nxt;
    logic                    r_tick_pending, w_tick_pending_nxt;
    requester_t              r_rr_last, w_rr_last_nxt;
    logic [NUM_BALLS-1:0]    r_we, w_we_nxt;
    vel_vec_t                w_vel_nxt;
    logic signed [VEL_W-1:0] r_vel_x, r_vel_y;
    logic                    r_cue_ack, w_cue_ack_nxt;
    logic                    r_wall_ack, w_wall_ack_nxt;
    logic                    r_pair_ack, w_pair_ack_nxt;
    logic                    r_tick, w_tick_nxt;
    logic                    r_table_idle, w_table_idle_nxt;
    logic                    w_clear_locks, w_set_a, w_set_b;
    logic [IDX_W-1:0]        w_set_idx_a, w_set_idx_b;
    logic                    w_pair_a_locked, w_pair_b_locked;
    logic [NUM_BALLS-1:0]    w_lock_vec;
    logic                    w_cue_ok, w_wall_ok, w_pair_ok;

    ball_lock_table u_lock_table (
        .clk          (clk),
        .resetN       (resetN),
        .i_set_a      (w_set_a),
        .i_set_idx_a  (w_set_idx_a),
        .i_set_b      (w_set_b),
        .i_set_idx_b  (w_set_idx_b),
        .i_clear_all  (w_clear_locks),
        .i_look_idx_a (pairBallA),
        .i_look_idx_b (pairBallB),
        .o_locked_a   (w_pair_a_locked),
        .o_locked_b   (w_pair_b_locked),
        .o_lock_vec   (w_lock_vec)
    );

    // A requester whose ack is currently high still shows req this cycle,
    // so it is masked to avoid a second grant of the same transaction.
    assign w_cue_ok  = cueReq && !r_cue_ack && (&ballStopped)
                    && !lock_lookup(w_lock_vec, cueBall);
    assign w_wall_ok = wallReq && !r_wall_ack && !lock_lookup(w_lock_vec, wallBall);
    assign w_pair_ok = pairReq && !r_pair_ack && !w_pair_a_locked && !w_pair_b_locked;

    // Next-state, grant decision and next registered output values.
    always_comb begin
        w_state_nxt        = r_state;
        w_tick_pending_nxt = r_tick_pending;
        w_rr_last_nxt      = r_rr_last;
        w_we_nxt           = '0;
        w_vel_nxt          = '0;
        w_cue_ack_nxt      = 1'b0;
        w_wall_ack_nxt     = 1'b0;
        w_pair_ack_nxt     = 1'b0;
        w_tick_nxt         = 1'b0;
        w_clear_locks      = 1'b0;
        w_set_a            = 1'b0;
        w_set_idx_a        = '0;
        w_set_b            = 1'b0;
        w_set_idx_b        = '0;
        case (r_state)
            IDLE: begin
                if (r_tick_pending || startOfFrame) begin
                    w_tick_nxt         = 1'b1;
                    w_clear_locks      = 1'b1;
                    w_tick_pending_nxt = 1'b0;
                end else if (w_cue_ok) begin
                    w_we_nxt      = ball_onehot(cueBall);
                    w_vel_nxt.x   = cueVelX;
                    w_vel_nxt.y   = cueVelY;
                    w_cue_ack_nxt = 1'b1;
                    w_set_a       = 1'b1;
                    w_set_idx_a   = cueBall;
                end else if (w_wall_ok && (!w_pair_ok || (r_rr_last == REQ_PAIR))) begin
                    w_we_nxt       = ball_onehot(wallBall);
                    w_vel_nxt.x    = wallVelX;
                    w_vel_nxt.y    = wallVelY;
                    w_wall_ack_nxt = 1'b1;
                    w_set_a        = 1'b1;
                    w_set_idx_a    = wallBall;
                    w_rr_last_nxt  = REQ_WALL;
                end else if (w_pair_ok) begin
                    w_we_nxt      = ball_onehot(pairBallA);
                    w_vel_nxt.x   = pairVelAX;
                    w_vel_nxt.y   = pairVelAY;
                    w_set_a       = 1'b1;
                    w_set_idx_a   = pairBallA;
                    w_rr_last_nxt = REQ_PAIR;
                    // A pair naming the same ball twice collapses to the A write.
                    if (pairBallA == pairBallB) begin
                        w_pair_ack_nxt = 1'b1;
                    end else begin
                        w_state_nxt = WRITE_A;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WRITE_A: begin
                w_we_nxt       = ball_onehot(pairBallB);
                w_vel_nxt.x    = pairVelBX;
                w_vel_nxt.y    = pairVelBY;
                w_pair_ack_nxt = 1'b1;
                w_set_b        = 1'b1;
                w_set_idx_b    = pairBallB;
                w_state_nxt    = WRITE_B;
                if (startOfFrame) begin
                    w_tick_pending_nxt = 1'b1;
                end else begin
                    w_tick_pending_nxt = r_tick_pending;
                end
            end
            WRITE_B: begin
                w_state_nxt = IDLE;
                if (startOfFrame) begin
                    w_tick_pending_nxt = 1'b1;
                end else begin
                    w_tick_pending_nxt = r_tick_pending;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_table_idle_nxt = (&ballStopped) && (w_state_nxt == IDLE) && (w_we_nxt == '0);
    end

    // State, pending tick, round-robin memory and all registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state        <= IDLE;
            r_tick_pending <= 1'b0;
            r_rr_last      <= REQ_WALL;
            r_we           <= '0;
            r_vel_x        <= '0;
            r_vel_y        <= '0;
            r_cue_ack      <= 1'b0;
            r_wall_ack     <= 1'b0;
            r_pair_ack     <= 1'b0;
            r_tick         <= 1'b0;
            r_table_idle   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_tick_pending <= w_tick_pending_nxt;
            r_rr_last      <= w_rr_last_nxt;
            r_we           <= w_we_nxt;
            r_vel_x        <= w_vel_nxt.x;
            r_vel_y        <= w_vel_nxt.y;
            r_cue_ack      <= w_cue_ack_nxt;
            r_wall_ack     <= w_wall_ack_nxt;
            r_pair_ack     <= w_pair_ack_nxt;
            r_tick         <= w_tick_nxt;
            r_table_idle   <= w_table_idle_nxt;
        end
    end

    assign velocityWriteEnable = r_we;
    assign outVelocityX        = r_vel_x;
    assign outVelocityY        = r_vel_y;
    assign cueAck              = r_cue_ack;
    assign wallAck             = r_wall_ack;
    assign pairAck             = r_pair_ack;
    assign ballFrameTick       = r_tick;
    assign tableIdle           = r_table_idle;

endmodule

// File: tb/tb_ball_write_arbiter.sv
// Self-checking bench: directed scenarios plus randomized requesters, all
// compared cycle by cycle against a transaction-level reference model.
module tb_ball_write_arbiter;
    import ball_pkg::*;

    logic                    clk = 1'b0;
    logic                    resetN;
    logic                    startOfFrame;
    logic [NUM_BALLS-1:0]    ballStopped;
    logic                    cueReq, wallReq, pairReq;
    logic [IDX_W-1:0]        cueBall, wallBall, pairBallA, pairBallB;
    logic signed [VEL_W-1:0] cueVelX, cueVelY, wallVelX, wallVelY;
    logic signed [VEL_W-1:0] pairVelAX, pairVelAY, pairVelBX, pairVelBY;
    logic                    cueAck, wallAck, pairAck;
    logic [NUM_BALLS-1:0]    velocityWriteEnable;
    logic signed [VEL_W-1:0] outVelocityX, outVelocityY;
    logic                    ballFrameTick, tableIdle;

    always #5 clk = ~clk;

    ball_write_arbiter dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .ballStopped(ballStopped),
        .cueReq(cueReq), .cueBall(cueBall), .cueVelX(cueVelX), .cueVelY(cueVelY), .cueAck(cueAck),
        .wallReq(wallReq), .wallBall(wallBall), .wallVelX(wallVelX), .wallVelY(wallVelY),
        .wallAck(wallAck),
        .pairReq(pairReq), .pairBallA(pairBallA), .pairVelAX(pairVelAX), .pairVelAY(pairVelAY),
        .pairBallB(pairBallB), .pairVelBX(pairVelBX), .pairVelBY(pairVelBY), .pairAck(pairAck),
        .velocityWriteEnable(velocityWriteEnable), .outVelocityX(outVelocityX),
        .outVelocityY(outVelocityY), .ballFrameTick(ballFrameTick), .tableIdle(tableIdle)
    );

    // Expected outputs for one cycle.
    typedef struct packed {
        logic [NUM_BALLS-1:0]    we;
        logic signed [VEL_W-1:0] vx;
        logic signed [VEL_W-1:0] vy;
        logic                    cue_ack;
        logic                    wall_ack;
        logic                    pair_ack;
        logic                    tick;
        logic                    idle;
    } exp_t;

    int   n_checks = 0;
    int   n_fails  = 0;
    int   sof_gap  = 0;
    bit   rand_on  = 1'b0;
    exp_t exp_now;
    exp_t exp_q[$];            // outputs already committed by a granted pair
    bit [NUM_BALLS-1:0] m_locks;
    bit   m_pend;
    bit   m_last_pair;         // last wall/pair winner was the pair requester

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_now     = '0;
        m_locks     = '0;
        m_pend      = 1'b0;
        m_last_pair = 1'b0;
    endtask

    // Predict the outputs of the next cycle from the inputs now driven.
    task automatic model_step();
        exp_t n, b;
        bit   all_st, cue_ok, wall_ok, pair_ok;
        n      = '0;
        all_st = &ballStopped;
        if (exp_q.size() != 0) begin
            if (startOfFrame) m_pend = 1'b1;
            n = exp_q.pop_front();
        end else if (m_pend || startOfFrame) begin
            n.tick  = 1'b1;
            m_locks = '0;
            m_pend  = 1'b0;
        end else begin
            cue_ok  = cueReq && !exp_now.cue_ack && all_st && !m_locks[cueBall];
            wall_ok = wallReq && !exp_now.wall_ack && !m_locks[wallBall];
            pair_ok = pairReq && !exp_now.pair_ack && !m_locks[pairBallA] && !m_locks[pairBallB];
            if (cue_ok) begin
                n.we = 16'd1 << cueBall; n.vx = cueVelX; n.vy = cueVelY; n.cue_ack = 1'b1;
            end else if (wall_ok && (!pair_ok || m_last_pair)) begin
                n.we = 16'd1 << wallBall; n.vx = wallVelX; n.vy = wallVelY; n.wall_ack = 1'b1;
                m_last_pair = 1'b0;
            end else if (pair_ok) begin
                n.we = 16'd1 << pairBallA; n.vx = pairVelAX; n.vy = pairVelAY;
                m_last_pair = 1'b1;
                if (pairBallA == pairBallB) begin
                    n.pair_ack = 1'b1;
                end else begin
                    b = '0;
                    b.we = 16'd1 << pairBallB; b.vx = pairVelBX; b.vy = pairVelBY; b.pair_ack = 1'b1;
                    exp_q.push_back(b);
                    exp_q.push_back('0);
                end
            end
        end
        m_locks = m_locks | n.we;
        n.idle  = all_st && (exp_q.size() == 0) && (n.we == '0);
        exp_now = n;
    endtask

    task automatic compare_outputs();
        check_value("we",       32'(velocityWriteEnable), 32'(exp_now.we));
        check_value("vel_x",    32'(outVelocityX),        32'(exp_now.vx));
        check_value("vel_y",    32'(outVelocityY),        32'(exp_now.vy));
        check_value("cue_ack",  32'(cueAck),              32'(exp_now.cue_ack));
        check_value("wall_ack", 32'(wallAck),             32'(exp_now.wall_ack));
        check_value("pair_ack", 32'(pairAck),             32'(exp_now.pair_ack));
        check_value("tick",     32'(ballFrameTick),       32'(exp_now.tick));
        check_value("idle",     32'(tableIdle),           32'(exp_now.idle));
    endtask

    task automatic rand_inputs();
        if (!cueReq && !cueAck && $urandom_range(0, 15) == 0) begin
            cueReq = 1'b1; cueBall = IDX_W'($urandom);
            cueVelX = VEL_W'($urandom); cueVelY = VEL_W'($urandom);
        end
        if (!wallReq && !wallAck && $urandom_range(0, 3) == 0) begin
            wallReq = 1'b1; wallBall = IDX_W'($urandom);
            wallVelX = VEL_W'($urandom); wallVelY = VEL_W'($urandom);
        end
        if (!pairReq && !pairAck && $urandom_range(0, 5) == 0) begin
            pairReq = 1'b1; pairBallA = IDX_W'($urandom);
            pairBallB = ($urandom_range(0, 7) == 0) ? pairBallA : IDX_W'($urandom);
            pairVelAX = VEL_W'($urandom); pairVelAY = VEL_W'($urandom);
            pairVelBX = VEL_W'($urandom); pairVelBY = VEL_W'($urandom);
        end
        if ($urandom_range(0, 31) == 0)
            ballStopped = ($urandom_range(0, 1) == 1) ? '1 : NUM_BALLS'($urandom);
        if (sof_gap >= 4 && $urandom_range(0, 19) == 0) begin
            startOfFrame = 1'b1; sof_gap = 0;
        end
    endtask

    // One clock: predict, advance, check, then apply the requester handshake.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_outputs();
        if (cueAck)  cueReq  = 1'b0;
        if (wallAck) wallReq = 1'b0;
        if (pairAck) pairReq = 1'b0;
        startOfFrame = 1'b0;
        sof_gap++;
        if (rand_on) rand_inputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_sof();
        startOfFrame = 1'b1;
        sof_gap      = 0;
    endtask

    task automatic drain();
        ballStopped = '1;
        for (int i = 0; i < 200 && (cueReq || wallReq || pairReq); i++) begin
            if (sof_gap >= 8) pulse_sof();
            step();
        end
        check_value("drain_done", 32'(cueReq | wallReq | pairReq), 32'd0);
    endtask

    int nb, n_wall, n_pair;

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; ballStopped = '1;
        cueReq = 1'b0; wallReq = 1'b0; pairReq = 1'b0;
        cueBall = '0; wallBall = '0; pairBallA = '0; pairBallB = '0;
        cueVelX = '0; cueVelY = '0; wallVelX = '0; wallVelY = '0;
        pairVelAX = '0; pairVelAY = '0; pairVelBX = '0; pairVelBY = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_outputs();
        resetN = 1'b1;
        run(2);

        // Single wall write.
        wallReq = 1'b1; wallBall = 4'd3; wallVelX = 11'sd12; wallVelY = -11'sd7;
        step();
        check_value("wall_strobe", 32'(velocityWriteEnable), 32'h0008);
        check_value("wall_vy", 32'(outVelocityY), 32'hFFFF_FFF9);
        run(2);

        // Same ball again in the same frame waits for the tick.
        wallReq = 1'b1; wallBall = 4'd3; wallVelX = 11'sd5; wallVelY = 11'sd5;
        run(4);
        check_value("relock_held", 32'(wallReq), 32'd1);
        pulse_sof();
        step();
        check_value("relock_tick", 32'(ballFrameTick), 32'd1);
        step();
        check_value("relock_grant", 32'(wallAck), 32'd1);
        run(4);

        // Pair write (2,5).
        pairReq = 1'b1; pairBallA = 4'd2; pairBallB = 4'd5;
        pairVelAX = 11'sd40; pairVelAY = 11'sd0; pairVelBX = -11'sd40; pairVelBY = 11'sd0;
        step();
        check_value("pair_a_strobe", 32'(velocityWriteEnable), 32'h0004);
        check_value("pair_a_noack", 32'(pairAck), 32'd0);
        step();
        check_value("pair_b_strobe", 32'(velocityWriteEnable), 32'h0020);
        check_value("pair_b_vx", 32'(outVelocityX), 32'hFFFF_FFD8);
        run(2);

        // Pair and wall contending continuously with fresh balls.
        pulse_sof();
        run(5);
        nb = 0; n_wall = 0; n_pair = 0;
        for (int i = 0; i < 30; i++) begin
            if (!wallReq && !wallAck && nb <= 13) begin
                wallReq = 1'b1; wallBall = IDX_W'(nb); wallVelX = VEL_W'(nb); wallVelY = -11'sd1;
                nb++;
            end
            if (!pairReq && !pairAck && nb <= 13) begin
                pairReq = 1'b1; pairBallA = IDX_W'(nb); pairBallB = IDX_W'(nb + 1);
                pairVelAX = 11'sd7; pairVelAY = 11'sd8; pairVelBX = 11'sd9; pairVelBY = 11'sd10;
                nb += 2;
            end
            step();
            if (wallAck) n_wall++;
            if (pairAck) n_pair++;
        end
        check_value("alt_wall_served", 32'(n_wall >= 2), 32'd1);
        check_value("alt_pair_served", 32'(n_pair >= 2), 32'd1);
        drain();

        // Frame start during WRITE_A is deferred, not lost.
        pulse_sof();
        run(5);
        pairReq = 1'b1; pairBallA = 4'd6; pairBallB = 4'd7;
        step();
        check_value("sofa_a_strobe", 32'(velocityWriteEnable), 32'h0040);
        pulse_sof();
        step();
        check_value("sofa_b_strobe", 32'(velocityWriteEnable), 32'h0080);
        step();
        step();
        check_value("sofa_tick", 32'(ballFrameTick), 32'd1);
        check_value("sofa_tick_nostrobe", 32'(velocityWriteEnable), 32'd0);
        run(3);

        // Cue needs a still table, then beats a simultaneous wall request.
        ballStopped = 16'h7FFF;
        cueReq = 1'b1; cueBall = 4'd9; cueVelX = 11'sd100; cueVelY = -11'sd50;
        run(3);
        check_value("cue_blocked", 32'(cueReq), 32'd1);
        ballStopped = '1;
        wallReq = 1'b1; wallBall = 4'd10; wallVelX = 11'sd3; wallVelY = 11'sd4;
        step();
        check_value("cue_first", 32'(cueAck), 32'd1);
        check_value("cue_strobe", 32'(velocityWriteEnable), 32'h0200);
        step();
        check_value("wall_after_cue", 32'(wallAck), 32'd1);
        run(2);

        // Randomized traffic.
        rand_on = 1'b1;
        run(4000);
        rand_on = 1'b0;
        drain();

        // Reset in WRITE_A aborts the pair.
        pulse_sof();
        run(5);
        pairReq = 1'b1; pairBallA = 4'd12; pairBallB = 4'd13;
        step();
        check_value("rst_pair_a", 32'(velocityWriteEnable), 32'h1000);
        resetN = 1'b0;
        #1;
        check_value("rst_we",   32'(velocityWriteEnable), 32'd0);
        check_value("rst_ack",  32'({cueAck, wallAck, pairAck}), 32'd0);
        check_value("rst_tick", 32'({ballFrameTick, tableIdle}), 32'd0);
        check_value("rst_vel",  32'({outVelocityX, outVelocityY}), 32'd0);
        pairReq = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_value("rst_no_b", 32'(velocityWriteEnable), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
